// File: rtl/count_pkg.sv
// Shared encodings for the count_seq controller: command opcodes and FSM states.
package count_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_LOAD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN_UP = 2'b01,
    RUN_DN = 2'b10
  } state_e;

endpackage

// File: rtl/count_seq_updown_cnt.sv
// WIDTH-bit up/down counter register with synchronous clear, load and count enable.
module updown_cnt #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             down,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      // Natural modulo-2^WIDTH wrap gives the required roll-over in both directions.
      count <= down ? count - WIDTH'(1) : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_seq.sv
// Command-driven counter sequencer: accepts CLEAR/LOAD/UP/DOWN, steps the counter
// toward a stored limit and pulses done when it gets there.
module count_seq
  import count_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [WIDTH-1:0] limit;
  cmd_op_e          op;
  logic             accept;
  logic             running;
  logic             at_limit;
  logic             step_en;

  assign op = cmd_op_e'(cmd_op);

  // Ready depends only on registered state and abort, never on the command itself.
  assign cmd_ready = (state == IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  assign running  = (state == RUN_UP) || (state == RUN_DN);
  assign at_limit = (count == limit);
  assign step_en  = running && !abort && !at_limit;

  assign busy = running;
  assign dir  = (state == RUN_DN);

  updown_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept && (op == CMD_CLEAR)),
    .load      (accept && (op == CMD_LOAD)),
    .load_value(cmd_limit),
    .enable    (step_en),
    .down      (state == RUN_DN),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      limit <= '0;
      done  <= 1'b0;
    end else begin
      // Abort wins over reaching the limit, so an aborted sequence never reports done.
      done <= running && !abort && at_limit;
      case (state)
        IDLE: begin
          if (accept && (op == CMD_UP)) begin
            limit <= cmd_limit;
            state <= RUN_UP;
          end else if (accept && (op == CMD_DOWN)) begin
            limit <= cmd_limit;
            state <= RUN_DN;
          end
        end
        RUN_UP, RUN_DN: begin
          if (abort || at_limit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq.sv
// Self-checking bench for count_seq: directed scenarios plus randomized traffic
// against a cycle-level arithmetic reference model.
module tb_count_seq;

  localparam int W   = 6;
  localparam int MOD = 1 << W;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_limit;
  logic         abort;
  logic [W-1:0] count;
  logic         dir;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model: a counter value plus "is a sequence running, which way, to where".
  int m_count  = 0;
  int m_target = 0;
  bit m_busy   = 1'b0;
  bit m_down   = 1'b0;
  bit m_done   = 1'b0;

  count_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_limit(cmd_limit),
    .abort    (abort),
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs, then let the DUT take the edge.
  task automatic step();
    if (!rst) begin
      m_count = 0; m_target = 0; m_busy = 1'b0; m_down = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (abort) m_busy = 1'b0;
        else if (m_count == m_target) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else if (m_down) m_count = (m_count + MOD - 1) % MOD;
        else m_count = (m_count + 1) % MOD;
      end else if (cmd_valid && !abort) begin
        case (cmd_op)
          OP_CLEAR: m_count = 0;
          OP_LOAD:  m_count = int'(cmd_limit);
          OP_UP:    begin m_busy = 1'b1; m_down = 1'b0; m_target = int'(cmd_limit); end
          default:  begin m_busy = 1'b1; m_down = 1'b1; m_target = int'(cmd_limit); end
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int value);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_limit = W'(value);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_CLEAR; cmd_limit = '0; abort = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || busy !== 1'b0 || dir !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d busy=%b dir=%b done=%b, want 0/0/0/0", count, busy, dir, done);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b, want 1", cmd_ready);
    end
  endtask

  // LOAD start, then UP/DOWN to lim; expected trajectory derived from the step distance.
  task automatic run_seq(input bit down, input int start, input int lim, input string name);
    int steps;
    int exp_count;
    issue(OP_LOAD, start);
    checks++;
    if (count !== W'(start) || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_load: count=%0d ready=%b, want %0d/1", name, count, cmd_ready, start);
    end
    steps = down ? (start - lim + MOD) % MOD : (lim - start + MOD) % MOD;
    issue(down ? OP_DOWN : OP_UP, lim);
    for (int k = 0; k <= steps; k++) begin
      exp_count = down ? (start - k + MOD) % MOD : (start + k) % MOD;
      checks++;
      if (count !== W'(exp_count) || busy !== 1'b1 || dir !== down || done !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_run[%0d]: count=%0d busy=%b dir=%b done=%b ready=%b, want %0d/1/%b/0/0",
                 name, k, count, busy, dir, done, cmd_ready, exp_count, down);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dir !== 1'b0 || count !== W'(lim) || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b dir=%b count=%0d ready=%b, want 1/0/0/%0d/1",
               name, done, busy, dir, count, cmd_ready, lim);
    end
    step();
    checks++;
    if (done !== 1'b0 || count !== W'(lim)) begin
      errors++;
      $display("FAIL %s_after: done=%b count=%0d, want 0/%0d", name, done, count, lim);
    end
  endtask

  task automatic test_sequences();
    run_seq(1'b0, 5, 8, "up_5_8");
    run_seq(1'b1, 2, 62, "dn_wrap_2_62");
    run_seq(1'b0, 10, 10, "up_equal_10");
    run_seq(1'b0, 60, 3, "up_wrap_60_3");
    run_seq(1'b1, 7, 7, "dn_equal_7");
    for (int i = 0; i < 4; i++) begin
      run_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)),
              int'($urandom_range(0, MOD - 1)), "rand_seq");
    end
  endtask

  task automatic test_abort();
    issue(OP_CLEAR, 0);
    issue(OP_UP, 20);
    for (int k = 0; k < 7; k++) step();
    checks++;
    if (count !== W'(7) || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: count=%0d busy=%b, want 7/1", count, busy);
    end
    abort = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: cmd_ready=%b, want 0", cmd_ready);
    end
    step();
    abort = 1'b0;
    checks++;
    if (count !== W'(7) || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: count=%0d busy=%b done=%b, want 7/0/0", count, busy, done);
    end
    step();
    checks++;
    if (count !== W'(7) || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: count=%0d done=%b, want 7/0", count, done);
    end
    // Abort on the very cycle the limit is reached must suppress done.
    issue(OP_LOAD, 3);
    issue(OP_UP, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== W'(3)) begin
      errors++;
      $display("FAIL abort_at_limit: done=%b busy=%b count=%0d, want 0/0/3", done, busy, count);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_at_limit_late: done=%b, want 0", done);
    end
    // Abort while idle blocks acceptance.
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_limit = W'(9);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_ready: cmd_ready=%b, want 0", cmd_ready);
    end
    step();
    cmd_valid = 1'b0; abort = 1'b0;
    checks++;
    if (count !== W'(3)) begin
      errors++;
      $display("FAIL abort_idle_hold: count=%0d, want 3", count);
    end
  endtask

  task automatic test_reset_mid();
    issue(OP_LOAD, 30);
    issue(OP_DOWN, 10);
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (count !== W'(27) || busy !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: count=%0d busy=%b dir=%b, want 27/1/1", count, busy, dir);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post: count=%0d busy=%b done=%b dir=%b ready=%b, want 0/0/0/0/1",
               count, busy, done, dir, cmd_ready);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_late: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    issue(OP_CLEAR, 0);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_limit = W'(4);
    step();
    cmd_op = OP_LOAD; cmd_limit = W'(40);
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (count !== W'(k) || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_run[%0d]: count=%0d ready=%b busy=%b, want %0d/0/1", k, count, cmd_ready, busy, k);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || count !== W'(4)) begin
      errors++;
      $display("FAIL b2b_done: done=%b ready=%b count=%0d, want 1/1/4", done, cmd_ready, count);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (count !== W'(40) || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: count=%0d busy=%b done=%b, want 40/0/0", count, busy, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) != 0);
      abort     = ($urandom_range(0, 24) == 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      // Bias limits near the current value so equal-at-acceptance and short runs occur often.
      if ($urandom_range(0, 1) == 1) cmd_limit = W'(m_count + int'($urandom_range(0, 4)));
      else cmd_limit = W'($urandom_range(0, MOD - 1));
      #1;
      checks++;
      if (count !== W'(m_count) || busy !== m_busy || dir !== (m_busy && m_down) ||
          done !== m_done || cmd_ready !== (!m_busy && !abort)) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d busy=%b dir=%b done=%b ready=%b, want %0d/%b/%b/%b/%b",
                 i, count, busy, dir, done, cmd_ready, m_count, m_busy, m_busy && m_down, m_done,
                 !m_busy && !abort);
      end
      step();
    end
    rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
